gate_bist_ctrl: RTL



---
 rtl/gate_bist_ctrl_if.sv | 40 ++++
 rtl/gate_bist_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_ctrl_if
// Brief    : Bundle between the BIST sequencer, system control and the
//            2-input gate unit (run control, gate stimulus/response, results).
// Revision : 1.0 - initial release
// ============================================================================
interface gate_bist_ctrl_if;
    // Run control from system side
    logic       start;
    logic       abort;
    // Gate unit response
    logic [7:0] y_in;
    // Gate unit stimulus
    logic       a_out;
    logic       b_out;
    // Status and results
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_mask;
    logic [7:0] err_count;
    logic [1:0] first_fail_vec;
    logic [7:0] first_fail_y;

    // Environment side: system control plus the gate unit response
    modport master (
        output start, abort, y_in,
        input  a_out, b_out, busy, done, pass,
        input  err_mask, err_count, first_fail_vec, first_fail_y
    );

    // Sequencer side
    modport slave (
        input  start, abort, y_in,
        output a_out, b_out, busy, done, pass,
        output err_mask, err_count, first_fail_vec, first_fail_y
    );
endinterface
`default_nettype wire

// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_ctrl
// Brief    : Self-test sequencer for the 2-input gate unit. Sweeps {A,B}
//            through 00..11, waits a settle time, compares Y against a golden
//            table and accumulates mask, saturating count and first failure.
// Revision : 1.0 - initial release
// ============================================================================
module gate_bist_ctrl #(
    parameter int          SETTLE_CYCLES = 2,
    parameter int          NUM_PASSES    = 1,
    parameter logic [31:0] EXP_VEC       = 32'h239656EC
) (
    input wire              clk,
    input wire              rst_n,
    gate_bist_ctrl_if.slave bus
);

    localparam int c_SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int c_PCW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [c_SCW-1:0] c_SETTLE_LOAD = c_SCW'(SETTLE_CYCLES);
    localparam logic [c_PCW-1:0] c_LAST_PASS   = c_PCW'(NUM_PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [c_PCW-1:0] r_pass_cnt;
    logic [c_SCW-1:0] r_settle_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_err_mask;
    logic [7:0]       r_err_count;
    logic [1:0]       r_ff_vec;
    logic [7:0]       r_ff_y;

    logic [7:0]       w_exp_y;
    logic             w_mismatch;
    logic             w_launch;

    // Golden byte for the current vector and run-launch qualification
    assign w_exp_y    = EXP_VEC[{r_idx, 3'b000} +: 8];
    assign w_mismatch = (bus.y_in != w_exp_y);
    assign w_launch   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Sequencer FSM; every output is a register so the gate inputs never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_pass_cnt   <= '0;
            r_settle_cnt <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_mask   <= 4'd0;
            r_err_count  <= 8'd0;
            r_ff_vec     <= 2'd0;
            r_ff_y       <= 8'd0;
        end else begin
            r_done <= 1'b0;
            if (w_launch) begin
                // Fresh run: results from the previous run are discarded here
                r_state     <= S_APPLY;
                r_idx       <= 2'd0;
                r_pass_cnt  <= '0;
                r_busy      <= 1'b1;
                r_pass      <= 1'b0;
                r_err_mask  <= 4'd0;
                r_err_count <= 8'd0;
                r_ff_vec    <= 2'd0;
                r_ff_y      <= 8'd0;
            end else if (r_busy && bus.abort) begin
                // Partial results stay visible; only control state is dropped
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
                r_a     <= 1'b0;
                r_b     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_APPLY: begin
                        {r_a, r_b}   <= r_idx;
                        r_settle_cnt <= c_SETTLE_LOAD;
                        r_state      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt <= c_SCW'(1)) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - c_SCW'(1);
                        end
                    end
                    S_CHECK: begin
                        if (w_mismatch) begin
                            r_err_mask[r_idx] <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            // A zero count means no earlier mismatch in this run
                            if (r_err_count == 8'd0) begin
                                r_ff_vec <= r_idx;
                                r_ff_y   <= bus.y_in;
                            end
                        end
                        r_state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (r_idx != 2'd3) begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= S_APPLY;
                        end else if (r_pass_cnt != c_LAST_PASS) begin
                            r_pass_cnt <= r_pass_cnt + c_PCW'(1);
                            r_idx      <= 2'd0;
                            r_state    <= S_APPLY;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_count == 8'd0);
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.a_out          = r_a;
    assign bus.b_out          = r_b;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_mask       = r_err_mask;
    assign bus.err_count      = r_err_count;
    assign bus.first_fail_vec = r_ff_vec;
    assign bus.first_fail_y   = r_ff_y;

endmodule
`default_nettype wire
